hwpe_ctrl_seq_div: RTL and testbench

Fully sequential restoring divider that produces one quotient bit per cycle. It is the inverse counterpart of the sequential multiplier and sits alongside it in the HWPE controller's arithmetic helpers. It computes loop bounds, strides and tile counts from register-file values without a combinational divider. Operands are latched on the start strobe, so callers need not hold inputs stable.

---
 rtl/hwpe_ctrl_seq_div.sv | 176 +++++++++++++++++
 tb/tb_hwpe_ctrl_seq_div.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_seq_div.sv
// Sequential restoring divider: one quotient bit per cycle, operands latched on start.
// Define HWPE_CTRL_SEQ_DIV_SIGNED_EN to add the signed_i port and a sign-fixup (FIX) state.
module hwpe_ctrl_seq_div #(
  parameter int unsigned NW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
  input  logic          signed_i,
`endif
  output logic          valid_o,
  output logic          ready_o,
  output logic [NW-1:0] quot_o,
  output logic [DW-1:0] rem_o,
  output logic          div_by_zero_o
);

  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, FIX = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW:0]   prem_q, prem_d;
  logic [NW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] dvs_q, dvs_d;
  logic [NW-1:0] quot_q, quot_d;
  logic [DW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [DW:0]   r_shift, r_sub, r_next;
  logic          q_bit;
  logic [NW-1:0] dvd_next, dvd_load;
  logic [DW-1:0] dvs_load;

`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
  logic sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;
  logic dvd_neg, dvs_neg;

  // Magnitudes at latch time; the most-negative value maps onto itself as an unsigned magnitude.
  always_comb begin
    dvd_neg  = signed_i && dividend_i[NW-1];
    dvs_neg  = signed_i && divisor_i[DW-1];
    dvd_load = dvd_neg ? -dividend_i : dividend_i;
    dvs_load = dvs_neg ? -divisor_i  : divisor_i;
  end
`else
  assign dvd_load = dividend_i;
  assign dvs_load = divisor_i;
`endif

  // Quotient bits shift into the dividend register as its MSBs are consumed.
  always_comb begin
    r_shift  = {prem_q[DW-1:0], dvd_q[NW-1]};
    r_sub    = r_shift - {1'b0, dvs_q};
    q_bit    = (r_shift >= {1'b0, dvs_q});
    r_next   = q_bit ? r_sub : r_shift;
    dvd_next = {dvd_q[NW-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CW'(NW - 1);
          prem_d  = '0;
          dvd_d   = dvd_load;
          dvs_d   = dvs_load;
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
          sgn_d   = signed_i;
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        prem_d = r_next;
        dvd_d  = dvd_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = dvd_next;
          rem_d   = r_next[DW-1:0];
          dbz_d   = (dvs_q == '0);
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
          if (sgn_q && (dvs_q != '0)) begin
            state_d = FIX;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dbz_d   = dbz_q;
          end
`endif
        end
      end
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
      FIX: begin
        state_d = DONE;
        quot_d  = qneg_q ? -dvd_q : dvd_q;
        rem_d   = rneg_q ? -prem_q[DW-1:0] : prem_q[DW-1:0];
        dbz_d   = 1'b0;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
      quot_d  = '0;
      rem_d   = '0;
      dbz_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign valid_o       = (state_q == DONE);
  assign ready_o       = (state_q == IDLE) || (state_q == DONE);
  assign quot_o        = quot_q;
  assign rem_o         = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_div.sv
// Directed self-checking bench for hwpe_ctrl_seq_div (NW=DW=8).
// Signed scenarios are compiled in when HWPE_CTRL_SEQ_DIV_SIGNED_EN is defined.
module tb_hwpe_ctrl_seq_div;

  localparam int unsigned NW = 8;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] dividend = '0;
  logic [DW-1:0] divisor = '0;
  logic          sgn = 1'b0;
  logic          valid, ready, dbz;
  logic [NW-1:0] quot;
  logic [DW-1:0] rem;

  int errors = 0;
  int checks = 0;

  hwpe_ctrl_seq_div #(.NW(NW), .DW(DW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
    .signed_i      (sgn),
`endif
    .valid_o       (valid),
    .ready_o       (ready),
    .quot_o        (quot),
    .rem_o         (rem),
    .div_by_zero_o (dbz)
  );

  always #5 clk = ~clk;

  // Drives a one-cycle start; returns just after the accepting edge (end of cycle T)
  // with the inputs scrambled so only latched operands can produce the result.
  task automatic launch(input logic [NW-1:0] a, input logic [DW-1:0] b, input logic s);
    @(negedge clk);
    dividend = a; divisor = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'hA5; divisor = 8'h5A; sgn = ~s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, ready, quot, rem, dbz} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b quot=%h rem=%h dbz=%b, want 0 1 00 00 0", valid, ready, quot, rem, dbz);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    launch(8'd200, 8'd7, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy T+%0d: ready=%b valid=%b, want 0 0", k, ready, valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, ready, quot, rem, dbz} !== {1'b1, 1'b1, 8'd28, 8'd4, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: valid=%b ready=%b quot=%0d rem=%0d dbz=%b, want 1 1 28 4 0", valid, ready, quot, rem, dbz);
    end
    @(negedge clk);
    checks++;
    if ({valid, ready, quot, rem} !== {1'b0, 1'b1, 8'd28, 8'd4}) begin
      errors++;
      $display("FAIL basic_hold: valid=%b ready=%b quot=%0d rem=%0d, want 0 1 28 4", valid, ready, quot, rem);
    end
  endtask

  task automatic test_div_zero();
    launch(8'd13, 8'd0, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL dz_early: valid=%b at T+8, want 0", valid);
    end
    @(negedge clk);
    checks++;
    if ({valid, quot, rem, dbz} !== {1'b1, 8'hFF, 8'd13, 1'b1}) begin
      errors++;
      $display("FAIL dz_result: valid=%b quot=%h rem=%0d dbz=%b, want 1 ff 13 1", valid, quot, rem, dbz);
    end
    launch(8'd10, 8'd3, 1'b0);
    repeat (8) @(negedge clk);
    checks++;
    if (dbz !== 1'b1) begin
      errors++;
      $display("FAIL dz_held: dbz=%b during next op, want 1", dbz);
    end
    @(negedge clk);
    checks++;
    if ({valid, quot, rem, dbz} !== {1'b1, 8'd3, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL dz_clear: valid=%b quot=%0d rem=%0d dbz=%b, want 1 3 1 0", valid, quot, rem, dbz);
    end
  endtask

  task automatic test_back_to_back();
    launch(8'd255, 8'd16, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_busy1 T+%0d: ready=%b valid=%b, want 0 0", k, ready, valid);
      end
      if (k == 4) begin
        dividend = 8'd1; divisor = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, ready, quot, rem} !== {1'b1, 1'b1, 8'd15, 8'd15}) begin
      errors++;
      $display("FAIL b2b_first: valid=%b ready=%b quot=%0d rem=%0d, want 1 1 15 15", valid, ready, quot, rem);
    end
    dividend = 8'd9; divisor = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'h33; divisor = 8'h02;
    for (int k = 10; k <= 17; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || valid !== 1'b0 || quot !== 8'd15) begin
        errors++;
        $display("FAIL b2b_busy2 T+%0d: ready=%b valid=%b quot=%0d, want 0 0 15", k, ready, valid, quot);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, quot, rem} !== {1'b1, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL b2b_second: valid=%b quot=%0d rem=%0d, want 1 1 0", valid, quot, rem);
    end
  endtask

  task automatic test_clear();
    logic seen;
    launch(8'd100, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    clear = 1'b1; start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({valid, ready, quot, rem, dbz} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL clear_state: valid=%b ready=%b quot=%h rem=%h dbz=%b, want 0 1 00 00 0", valid, ready, quot, rem, dbz);
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (valid !== 1'b0 || ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clear_quiet: activity after clear=%b, want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    launch(8'd10, 8'd3, 1'b0);
    repeat (9) @(negedge clk);
    launch(8'd200, 8'd7, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({valid, ready, quot, rem, dbz} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b quot=%h rem=%h dbz=%b, want 0 1 00 00 0", valid, ready, quot, rem, dbz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (valid !== 1'b0 || ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet: activity after reset=%b, want 0", seen);
    end
  endtask

`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    launch(8'hF9, 8'd2, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL signed_busy T+%0d: ready=%b valid=%b, want 0 0", k, ready, valid);
      end
    end
    @(negedge clk);
    checks++;
    if ({valid, quot, rem, dbz} !== {1'b1, 8'hFD, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL signed_m7d2: valid=%b quot=%h rem=%h dbz=%b, want 1 fd ff 0", valid, quot, rem, dbz);
    end
    launch(8'h80, 8'hFF, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if ({valid, quot, rem} !== {1'b1, 8'h80, 8'h00}) begin
      errors++;
      $display("FAIL signed_wrap: valid=%b quot=%h rem=%h, want 1 80 00", valid, quot, rem);
    end
    launch(8'hF9, 8'd2, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if ({valid, quot, rem} !== {1'b1, 8'd124, 8'd1}) begin
      errors++;
      $display("FAIL unsigned_mode: valid=%b quot=%0d rem=%0d, want 1 124 1", valid, quot, rem);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_back_to_back();
    test_clear();
    test_async_reset();
`ifdef HWPE_CTRL_SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
